// File: rtl/x_calc_sched.sv
// x_calc_sched: replays the H/Y buffers into x_calculate once per
// q iteration and streams each iteration's result out.
module x_calc_sched #(
  parameter int N       = 32,
  parameter int NQ_MAX  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_start,
  input  logic [4:0]   cfg_num_q,
  input  logic         h_wr_en,
  input  logic [3:0]   h_wr_addr,
  input  logic [N-1:0] h_wr_r,
  input  logic [N-1:0] h_wr_i,
  input  logic         y_wr_en,
  input  logic [2:0]   y_wr_addr,
  input  logic [N-1:0] y_wr_r,
  input  logic [N-1:0] y_wr_i,
  output logic         busy,
  output logic         all_done,
  output logic         err,
  output logic         dp_start_new_q,
  output logic [3:0]   dp_q_index,
  output logic         dp_H_in_valid,
  output logic [N-1:0] dp_H_in_r,
  output logic [N-1:0] dp_H_in_i,
  output logic         dp_Y_in_valid,
  output logic [N-1:0] dp_Y_in_r,
  output logic [N-1:0] dp_Y_in_i,
  input  logic         dp_q_done,
  input  logic [N-1:0] dp_xI1,
  input  logic [N-1:0] dp_xQ1,
  input  logic [N-1:0] dp_xI2,
  input  logic [N-1:0] dp_xQ2,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [3:0]   res_q_index,
  output logic [N-1:0] res_xI1,
  output logic [N-1:0] res_xQ1,
  output logic [N-1:0] res_xI2,
  output logic [N-1:0] res_xQ2
);

  typedef enum logic [2:0] {
    IDLE, START, LOAD, WAIT, OUT, DONE
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [4:0] NQ_SAT = 5'(NQ_MAX);

  state_t state, state_n;

  logic [4:0]    q;
  logic [4:0]    num_q;
  logic [3:0]    k;
  logic [TW-1:0] to_cnt;
  logic [4:0]    nq_sat;
  logic [4:0]    q_nxt;

  logic [N-1:0] h_r [16];
  logic [N-1:0] h_i [16];
  logic [N-1:0] y_r [8];
  logic [N-1:0] y_i [8];

  assign nq_sat = (cfg_num_q > NQ_SAT) ? NQ_SAT : cfg_num_q;
  assign q_nxt  = q + 5'd1;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (cfg_start)
          state_n = (cfg_num_q == 5'd0) ? DONE : START;
      START: state_n = LOAD;
      LOAD:
        if (k == 4'd15) state_n = WAIT;
      WAIT:
        if (dp_q_done) state_n = OUT;
        else if (to_cnt == TO_LAST) state_n = IDLE;
      OUT:
        if (res_ready)
          state_n = (q_nxt == num_q) ? DONE : START;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      q           <= '0;
      num_q       <= '0;
      k           <= '0;
      to_cnt      <= '0;
      err         <= 1'b0;
      res_q_index <= '0;
      res_xI1     <= '0;
      res_xQ1     <= '0;
      res_xI2     <= '0;
      res_xQ2     <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE:
          if (cfg_start) begin
            err   <= 1'b0;
            q     <= '0;
            num_q <= nq_sat;
          end
        START: k <= '0;
        LOAD: begin
          k      <= k + 4'd1;
          to_cnt <= '0;
        end
        WAIT:
          if (dp_q_done) begin
            res_q_index <= q[3:0];
            res_xI1     <= dp_xI1;
            res_xQ1     <= dp_xQ1;
            res_xI2     <= dp_xI2;
            res_xQ2     <= dp_xQ2;
          end else if (to_cnt == TO_LAST) begin
            err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        OUT:
          if (res_ready) q <= q_nxt;
        DONE: ;
        default: ;
      endcase
    end
  end

  // Buffers are frozen for the whole run so every q sees the same data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 16; j++) begin
        h_r[j] <= '0;
        h_i[j] <= '0;
      end
      for (int j = 0; j < 8; j++) begin
        y_r[j] <= '0;
        y_i[j] <= '0;
      end
    end else begin
      if (h_wr_en && !busy) begin
        h_r[h_wr_addr] <= h_wr_r;
        h_i[h_wr_addr] <= h_wr_i;
      end
      if (y_wr_en && !busy) begin
        y_r[y_wr_addr] <= y_wr_r;
        y_i[y_wr_addr] <= y_wr_i;
      end
    end
  end

  assign busy = (state == START) || (state == LOAD) ||
                (state == WAIT) || (state == OUT);
  assign all_done       = (state == DONE);
  assign dp_start_new_q = (state == START);
  assign dp_q_index     = q[3:0];
  assign res_valid      = (state == OUT);

  assign dp_H_in_valid = (state == LOAD);
  assign dp_Y_in_valid = (state == LOAD) && !k[3];
  assign dp_H_in_r = dp_H_in_valid ? h_r[k] : '0;
  assign dp_H_in_i = dp_H_in_valid ? h_i[k] : '0;
  assign dp_Y_in_r = dp_Y_in_valid ? y_r[k[2:0]] : '0;
  assign dp_Y_in_i = dp_Y_in_valid ? y_i[k[2:0]] : '0;

endmodule

// File: tb/tb_x_calc_sched.sv
// tb_x_calc_sched: directed bench with a behavioural x_calculate
// responder and a negedge monitor of every datapath strobe.
module tb_x_calc_sched;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         cfg_start = 0;
  logic [4:0]   cfg_num_q = 0;
  logic         h_wr_en = 0;
  logic [3:0]   h_wr_addr = 0;
  logic [N-1:0] h_wr_r = 0, h_wr_i = 0;
  logic         y_wr_en = 0;
  logic [2:0]   y_wr_addr = 0;
  logic [N-1:0] y_wr_r = 0, y_wr_i = 0;
  logic         busy, all_done, err;
  logic         dp_start_new_q;
  logic [3:0]   dp_q_index;
  logic         dp_H_in_valid, dp_Y_in_valid;
  logic [N-1:0] dp_H_in_r, dp_H_in_i, dp_Y_in_r, dp_Y_in_i;
  logic         dp_q_done = 0;
  logic [N-1:0] dp_xI1 = 0, dp_xQ1 = 0, dp_xI2 = 0, dp_xQ2 = 0;
  logic         res_valid;
  logic         res_ready = 1;
  logic [3:0]   res_q_index;
  logic [N-1:0] res_xI1, res_xQ1, res_xI2, res_xQ2;

  x_calc_sched #(.N(N), .NQ_MAX(16), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_num_q(cfg_num_q),
    .h_wr_en(h_wr_en), .h_wr_addr(h_wr_addr),
    .h_wr_r(h_wr_r), .h_wr_i(h_wr_i),
    .y_wr_en(y_wr_en), .y_wr_addr(y_wr_addr),
    .y_wr_r(y_wr_r), .y_wr_i(y_wr_i),
    .busy(busy), .all_done(all_done), .err(err),
    .dp_start_new_q(dp_start_new_q), .dp_q_index(dp_q_index),
    .dp_H_in_valid(dp_H_in_valid),
    .dp_H_in_r(dp_H_in_r), .dp_H_in_i(dp_H_in_i),
    .dp_Y_in_valid(dp_Y_in_valid),
    .dp_Y_in_r(dp_Y_in_r), .dp_Y_in_i(dp_Y_in_i),
    .dp_q_done(dp_q_done),
    .dp_xI1(dp_xI1), .dp_xQ1(dp_xQ1),
    .dp_xI2(dp_xI2), .dp_xQ2(dp_xQ2),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_q_index(res_q_index),
    .res_xI1(res_xI1), .res_xQ1(res_xQ1),
    .res_xI2(res_xI2), .res_xQ2(res_xQ2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_start, n_done, zero_viol;
  int hs_cyc, done_cyc, last_h_cyc, err_cyc;
  int start_q[$];
  logic [N-1:0] hb_r[$], hb_i[$], yb_r[$], yb_i[$];
  int res_idx[$];
  logic [N-1:0] rx_i1[$], rx_q1[$], rx_i2[$], rx_q2[$];
  logic prev_err;
  int lb, since, qd_delay, cur_q;
  bit armed;

  initial begin
    n_start = 0; n_done = 0; zero_viol = 0;
    hs_cyc = 0; done_cyc = 0; last_h_cyc = 0; err_cyc = 0;
    prev_err = 0; lb = 0; since = 0; qd_delay = 5; cur_q = 0;
    armed = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      lb = 0;
      armed = 0;
      prev_err = 0;
    end else begin
      if (dp_start_new_q) begin
        n_start++;
        start_q.push_back(int'(dp_q_index));
        cur_q = int'(dp_q_index);
        lb = 0;
      end
      if (dp_H_in_valid) begin
        hb_r.push_back(dp_H_in_r);
        hb_i.push_back(dp_H_in_i);
        last_h_cyc = cyc;
        lb++;
        if (lb == 16) begin
          armed = 1;
          since = 0;
        end
      end else if (dp_H_in_r != 0 || dp_H_in_i != 0) begin
        zero_viol++;
      end
      if (dp_Y_in_valid) begin
        yb_r.push_back(dp_Y_in_r);
        yb_i.push_back(dp_Y_in_i);
      end else if (dp_Y_in_r != 0 || dp_Y_in_i != 0) begin
        zero_viol++;
      end
      if (res_valid && res_ready) begin
        res_idx.push_back(int'(res_q_index));
        rx_i1.push_back(res_xI1);
        rx_q1.push_back(res_xQ1);
        rx_i2.push_back(res_xI2);
        rx_q2.push_back(res_xQ2);
        hs_cyc = cyc;
      end
      if (all_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (err && !prev_err) err_cyc = cyc;
      prev_err = err;
    end
  end

  // x_calculate stand-in: garbage on x* except in the q_done cycle
  initial forever begin
    @(posedge clk);
    #1;
    if (armed) since++;
    if (armed && since == qd_delay) begin
      armed = 0;
      dp_q_done = 1;
      dp_xI1 = 32'hA000 + cur_q;
      dp_xQ1 = 32'hB000 + cur_q;
      dp_xI2 = 32'hC000 + cur_q;
      dp_xQ2 = 32'hD000 + cur_q;
    end else begin
      dp_q_done = 0;
      dp_xI1 = 32'hF100_0000 | cyc;
      dp_xQ1 = 32'hF200_0000 | cyc;
      dp_xI2 = 32'hF300_0000 | cyc;
      dp_xQ2 = 32'hF400_0000 | cyc;
    end
  end

  task automatic clear_mon();
    n_start = 0; n_done = 0;
    hs_cyc = 0; done_cyc = 0; err_cyc = 0;
    start_q.delete();
    hb_r.delete(); hb_i.delete();
    yb_r.delete(); yb_i.delete();
    res_idx.delete();
    rx_i1.delete(); rx_q1.delete();
    rx_i2.delete(); rx_q2.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_h(input int a, input logic [N-1:0] r,
                      input logic [N-1:0] i);
    h_wr_en = 1; h_wr_addr = 4'(a); h_wr_r = r; h_wr_i = i;
    @(posedge clk);
    #1;
    h_wr_en = 0;
  endtask

  task automatic wr_y(input int a, input logic [N-1:0] r,
                      input logic [N-1:0] i);
    y_wr_en = 1; y_wr_addr = 3'(a); y_wr_r = r; y_wr_i = i;
    @(posedge clk);
    #1;
    y_wr_en = 0;
  endtask

  task automatic load_bufs();
    for (int a = 0; a < 16; a++) wr_h(a, N'(a + 1), N'(32'h200 + a));
    for (int a = 0; a < 8; a++) wr_y(a, N'(32'h100 + a), N'(32'h300 + a));
  endtask

  task automatic start_run(input logic [4:0] nq);
    cfg_num_q = nq;
    cfg_start = 1;
    @(posedge clk);
    #1;
    cfg_start = 0;
  endtask

  task automatic wait_end(input int budget);
    bit hit;
    hit = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (all_done || err) begin
        hit = 1;
        break;
      end
    end
    if (!hit) check("wait_end_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string t, input int nq,
                           input bit zero_buf);
    int bad;
    int kk;
    check({t, "_starts"}, n_start, nq);
    bad = 0;
    foreach (start_q[i]) if (start_q[i] != i) bad++;
    check({t, "_qorder"}, bad, 0);
    check({t, "_nres"}, res_idx.size(), nq);
    bad = 0;
    foreach (res_idx[i])
      if (res_idx[i] != i || rx_i1[i] != N'(32'hA000 + i) ||
          rx_q1[i] != N'(32'hB000 + i) ||
          rx_i2[i] != N'(32'hC000 + i) ||
          rx_q2[i] != N'(32'hD000 + i)) bad++;
    check({t, "_res"}, bad, 0);
    check({t, "_nh"}, hb_r.size(), 16 * nq);
    check({t, "_ny"}, yb_r.size(), 8 * nq);
    bad = 0;
    foreach (hb_r[i]) begin
      kk = i % 16;
      if (zero_buf) begin
        if (hb_r[i] != 0 || hb_i[i] != 0) bad++;
      end else if (hb_r[i] != N'(kk + 1) ||
                   hb_i[i] != N'(32'h200 + kk)) bad++;
    end
    check({t, "_horder"}, bad, 0);
    bad = 0;
    foreach (yb_r[i]) begin
      kk = i % 8;
      if (zero_buf) begin
        if (yb_r[i] != 0 || yb_i[i] != 0) bad++;
      end else if (yb_r[i] != N'(32'h100 + kk) ||
                   yb_i[i] != N'(32'h300 + kk)) bad++;
    end
    check({t, "_yorder"}, bad, 0);
    check({t, "_ndone"}, n_done, 1);
    check({t, "_done_lat"}, done_cyc - hs_cyc, 1);
  endtask

  logic [3:0]   s_idx;
  logic [N-1:0] s_i1, s_q1, s_i2, s_q2;
  int diffs, hold_starts;
  bit seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {busy, all_done, err, dp_start_new_q,
                      dp_H_in_valid, dp_Y_in_valid, res_valid}, 0);
    check("rst_data", dp_H_in_r | dp_H_in_i | dp_Y_in_r | dp_Y_in_i |
                      res_xI1 | res_xQ1 | res_xI2 | res_xQ2 |
                      N'(res_q_index) | N'(dp_q_index), 0);
    rst = 1;
    tick(2);

    // single iteration, latency checks
    load_bufs();
    clear_mon();
    start_run(1);
    @(negedge clk);
    check("t1_start_lat", {dp_start_new_q, busy, dp_q_index}, {2'b11, 4'd0});
    @(negedge clk);
    check("t1_h_lat", {dp_H_in_valid, dp_H_in_r}, {1'b1, 32'd1});
    @(posedge clk);
    #1;
    wait_end(200);
    check_run("t1", 1, 0);
    check("t1_err", err, 0);

    clear_mon();
    start_run(16);
    wait_end(2000);
    check_run("t2", 16, 0);

    clear_mon();
    start_run(5'd20);
    wait_end(2000);
    check_run("sat", 16, 0);

    // back-pressure on the result stream
    clear_mon();
    res_ready = 0;
    start_run(2);
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1;
        break;
      end
    end
    check("t3_res_valid_seen", seen, 1);
    s_idx = res_q_index; s_i1 = res_xI1; s_q1 = res_xQ1;
    s_i2 = res_xI2; s_q2 = res_xQ2;
    diffs = 0;
    hold_starts = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (res_q_index != s_idx || res_xI1 != s_i1 || res_xQ1 != s_q1 ||
          res_xI2 != s_i2 || res_xQ2 != s_q2) diffs++;
      if (dp_start_new_q) hold_starts++;
    end
    check("t3_valid_held", res_valid, 1);
    check("t3_stable", diffs, 0);
    check("t3_no_start", hold_starts, 0);
    @(posedge clk);
    #1;
    res_ready = 1;
    wait_end(500);
    check_run("t3", 2, 0);

    // q_done never returned
    clear_mon();
    qd_delay = -1;
    start_run(1);
    wait_end(600);
    check("t4_err", err, 1);
    check("t4_busy", busy, 0);
    check("t4_ndone", n_done, 0);
    check("t4_nres", res_idx.size(), 0);
    check("t4_wait_len", err_cyc - last_h_cyc, 256);
    qd_delay = 5;
    clear_mon();
    start_run(1);
    @(negedge clk);
    check("t4_err_clear", err, 0);
    @(posedge clk);
    #1;
    wait_end(200);
    check_run("t4b", 1, 0);

    // reset in the middle of LOAD
    clear_mon();
    start_run(1);
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (dp_H_in_valid && dp_H_in_r == N'(8)) begin
        seen = 1;
        break;
      end
    end
    check("t5_beat7_seen", seen, 1);
    #1;
    rst = 0;
    #1;
    check("t5_rst_ctl", {busy, all_done, err, dp_start_new_q,
                         dp_H_in_valid, dp_Y_in_valid, res_valid}, 0);
    check("t5_rst_data", dp_H_in_r | dp_H_in_i | dp_Y_in_r | dp_Y_in_i |
                         res_xI1 | res_xQ1 | res_xI2 | res_xQ2 |
                         N'(res_q_index) | N'(dp_q_index), 0);
    tick(3);
    rst = 1;
    clear_mon();
    tick(6);
    check("t5_quiet", n_start + hb_r.size() + yb_r.size() + n_done, 0);
    start_run(1);
    wait_end(200);
    check_run("t5clr", 1, 1);
    load_bufs();
    clear_mon();
    start_run(1);
    wait_end(200);
    check_run("t5", 1, 0);

    // writes and starts while busy are ignored
    clear_mon();
    start_run(1);
    h_wr_en = 1; h_wr_addr = 0; h_wr_r = 32'hDEAD; h_wr_i = 32'hBEEF;
    cfg_start = 1; cfg_num_q = 5;
    @(posedge clk);
    #1;
    h_wr_en = 0;
    cfg_start = 0;
    wait_end(300);
    check_run("t6", 1, 0);
    clear_mon();
    start_run(1);
    wait_end(200);
    check_run("t6b", 1, 0);

    clear_mon();
    start_run(0);
    @(negedge clk);
    check("t7_done", {all_done, busy}, 2'b10);
    @(posedge clk);
    #1;
    tick(5);
    check("t7_no_strobe", n_start + hb_r.size() + yb_r.size(), 0);
    check("t7_ndone", n_done, 1);

    check("zero_data", zero_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
